// File: rtl/ber_fer_monitor_pkg.sv
// Shared types and helpers for the BER/FER monitor: FSM encoding, index widths
// and the saturating adder used by every statistics counter.
package ber_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        COUNT,
        CHECK,
        REPORT,
        DONE
    } state_t;

    localparam int SNR_W = 4;
    localparam int SAT_W = 64;

    function automatic int chunk_idx_width(input int dim, input int chunk);
        return (dim / chunk > 1) ? $clog2(dim / chunk) : 1;
    endfunction

    localparam int CHUNK_IDX_W = chunk_idx_width(2304, 64);

    // Adds incr to value and clamps the result at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] incr,
                                                 input int width);
        logic [SAT_W-1:0] limit;
        logic [SAT_W:0]   sum;
        limit = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        sum   = {1'b0, value} + {1'b0, incr};
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/ber_fer_monitor_if.sv
// Result-record channel: one record per SNR point, valid/ready handshake.
interface ber_fer_monitor_if
    import ber_mon_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [SNR_W-1:0] rpt_snr;
    logic [CNT_W-1:0] rpt_frames;
    logic [CNT_W-1:0] rpt_ferr;
    logic [CNT_W-1:0] rpt_berr;

    modport master (
        output rpt_valid, rpt_snr, rpt_frames, rpt_ferr, rpt_berr,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid, rpt_snr, rpt_frames, rpt_ferr, rpt_berr,
        output rpt_ready
    );
endinterface

// File: rtl/ber_fer_monitor_popcnt_chunk.sv
// Registered population count of one CHUNK-bit slice; result appears one cycle later.
module popcnt_chunk #(
    parameter int CHUNK = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHUNK-1:0]        data,
    output logic [$clog2(CHUNK):0]  count
);
    localparam int W = $clog2(CHUNK) + 1;

    logic [W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum = sum + W'(data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= sum;
        end
    end
endmodule

// File: rtl/ber_fer_monitor.sv
// BER/FER monitor: snapshots each decoded all-zero-codeword frame, counts frame and
// bit errors per SNR point and publishes one record per point while sweeping snr_idx.
module ber_fer_monitor
    import ber_mon_pkg::*;
#(
    parameter int DIM        = 2304,
    parameter int CHUNK      = 64,
    parameter int CNT_W      = 32,
    parameter int FE_TARGET  = 100,
    parameter int MAX_FRAMES = 100000,
    parameter int SNR_FIRST  = 0,
    parameter int SNR_LAST   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             term,
    input  logic             frame_err,
    input  logic [DIM-1:0]   res,
    output logic             stall,
    output logic [SNR_W-1:0] snr_idx,
    output logic             overrun,
    output logic             busy,
    output logic             done,
    ber_fer_monitor_if.master rpt
);
    localparam int NCHUNK = DIM / CHUNK;
    localparam int IDX_W  = chunk_idx_width(DIM, CHUNK);
    localparam int CW     = IDX_W + 1;
    localparam int POP_W  = $clog2(CHUNK) + 1;

    localparam logic [CW-1:0]    LAST_CNT = CW'(NCHUNK);
    localparam logic [CW-1:0]    CNT_STEP = CW'(1);
    localparam logic [SNR_W-1:0] SNR_F    = SNR_W'(SNR_FIRST);
    localparam logic [SNR_W-1:0] SNR_L    = SNR_W'(SNR_LAST);
    localparam logic [SNR_W-1:0] SNR_STEP = SNR_W'(1);
    localparam logic [CNT_W-1:0] FE_LIM   = CNT_W'(FE_TARGET);
    localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_FRAMES);

    state_t           state, state_next;
    logic             term_q;
    logic             term_edge;
    logic [DIM-1:0]   shadow;
    logic             ferr_q;
    logic [CW-1:0]    cnt;
    logic             pop_valid;
    logic [POP_W-1:0] pop_cnt;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] ferr;
    logic [CNT_W-1:0] berr;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value,
                                              input logic [SAT_W-1:0] incr);
        return CNT_W'(sat_add(SAT_W'(value), incr, CNT_W));
    endfunction

    assign term_edge = term && !term_q;

    popcnt_chunk #(.CHUNK(CHUNK)) u_popcnt (
        .clk   (clk),
        .rst   (rst),
        .data  (shadow[CHUNK-1:0]),
        .count (pop_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (term_edge) state_next = COUNT;
            COUNT:   if (cnt == LAST_CNT) state_next = CHECK;
            CHECK:   state_next = ((ferr >= FE_LIM) || (frames >= MAX_LIM)) ? REPORT : RUN;
            REPORT:  if (rpt.rpt_ready) state_next = (snr_idx == SNR_L) ? DONE : RUN;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall         = (state != RUN) || term_edge;
        busy          = (state != IDLE) && (state != DONE);
        done          = (state == DONE);
        rpt.rpt_valid = (state == REPORT);
    end

    assign rpt.rpt_snr    = snr_idx;
    assign rpt.rpt_frames = frames;
    assign rpt.rpt_ferr   = ferr;
    assign rpt.rpt_berr   = berr;

    // The shadow shifts right each COUNT cycle so the popcounter always sees the next chunk;
    // the extra COUNT cycle at cnt == LAST_CNT drains the registered sum of the final chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_q    <= 1'b1;
            shadow    <= '0;
            ferr_q    <= 1'b0;
            cnt       <= '0;
            pop_valid <= 1'b0;
            frames    <= '0;
            ferr      <= '0;
            berr      <= '0;
            snr_idx   <= SNR_F;
            overrun   <= 1'b0;
        end else begin
            term_q    <= term;
            pop_valid <= (state == COUNT) && (cnt != LAST_CNT);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        frames  <= '0;
                        ferr    <= '0;
                        berr    <= '0;
                        snr_idx <= SNR_F;
                        overrun <= 1'b0;
                    end
                end
                RUN: begin
                    if (term_edge) begin
                        shadow <= res;
                        ferr_q <= frame_err;
                        frames <= bump(frames, SAT_W'(1));
                        cnt    <= '0;
                    end
                end
                COUNT: begin
                    shadow <= shadow >> CHUNK;
                    if (cnt != LAST_CNT) cnt <= cnt + CNT_STEP;
                    if ((cnt == '0) && ferr_q) ferr <= bump(ferr, SAT_W'(1));
                    if (pop_valid) berr <= bump(berr, SAT_W'(pop_cnt));
                    if (term_edge) overrun <= 1'b1;
                end
                CHECK: begin
                    if (term_edge) overrun <= 1'b1;
                end
                REPORT: begin
                    if (term_edge) overrun <= 1'b1;
                    if (rpt.rpt_ready && (snr_idx != SNR_L)) begin
                        snr_idx <= snr_idx + SNR_STEP;
                        frames  <= '0;
                        ferr    <= '0;
                        berr    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ber_fer_monitor.sv
// Directed bench for ber_fer_monitor: two instances (single-point and 3..5 sweep) with a record scoreboard.
module tb_ber_fer_monitor;
    import ber_mon_pkg::*;

    localparam int DIM   = 2304;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [3:0]  snr;
        logic [31:0] frames;
        logic [31:0] ferr;
        logic [31:0] berr;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_s  [2];
    logic           term_s   [2];
    logic           ferr_s   [2];
    logic           ready_s  [2];
    logic [DIM-1:0] res_s    [2];
    logic           stall_o  [2];
    logic           overrun_o[2];
    logic           busy_o   [2];
    logic           done_o   [2];
    logic           valid_o  [2];
    logic [3:0]     snr_o    [2];
    logic [3:0]     rsnr_o   [2];
    logic [31:0]    frames_o [2];
    logic [31:0]    ferrc_o  [2];
    logic [31:0]    berr_o   [2];

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_frames[2];
    int   m_ferr  [2];
    int   m_berr  [2];
    int   m_snr   [2];
    rec_t exp_q[$];

    ber_fer_monitor_if #(.CNT_W(CNT_W)) rpt_a ();
    ber_fer_monitor_if #(.CNT_W(CNT_W)) rpt_b ();

    assign rpt_a.rpt_ready = ready_s[0];
    assign rpt_b.rpt_ready = ready_s[1];
    assign valid_o[0]  = rpt_a.rpt_valid;
    assign valid_o[1]  = rpt_b.rpt_valid;
    assign rsnr_o[0]   = rpt_a.rpt_snr;
    assign rsnr_o[1]   = rpt_b.rpt_snr;
    assign frames_o[0] = rpt_a.rpt_frames;
    assign frames_o[1] = rpt_b.rpt_frames;
    assign ferrc_o[0]  = rpt_a.rpt_ferr;
    assign ferrc_o[1]  = rpt_b.rpt_ferr;
    assign berr_o[0]   = rpt_a.rpt_berr;
    assign berr_o[1]   = rpt_b.rpt_berr;

    ber_fer_monitor #(
        .DIM(DIM), .CHUNK(64), .CNT_W(CNT_W), .FE_TARGET(2), .MAX_FRAMES(5),
        .SNR_FIRST(10), .SNR_LAST(10)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .term(term_s[0]), .frame_err(ferr_s[0]),
        .res(res_s[0]), .stall(stall_o[0]), .snr_idx(snr_o[0]), .overrun(overrun_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .rpt(rpt_a)
    );

    ber_fer_monitor #(
        .DIM(DIM), .CHUNK(64), .CNT_W(CNT_W), .FE_TARGET(1), .MAX_FRAMES(5),
        .SNR_FIRST(3), .SNR_LAST(5)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .term(term_s[1]), .frame_err(ferr_s[1]),
        .res(res_s[1]), .stall(stall_o[1]), .snr_idx(snr_o[1]), .overrun(overrun_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .rpt(rpt_b)
    );

    always #5 clk = ~clk;

    function automatic int feTarget(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    function automatic int snrFirst(input int sel);
        return (sel == 0) ? 10 : 3;
    endfunction

    function automatic int snrLast(input int sel);
        return (sel == 0) ? 10 : 5;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkIdle(input int sel, input int snr);
        checkOutput("rst_stall",   64'(stall_o[sel]),   64'(1));
        checkOutput("rst_busy",    64'(busy_o[sel]),    64'(0));
        checkOutput("rst_done",    64'(done_o[sel]),    64'(0));
        checkOutput("rst_valid",   64'(valid_o[sel]),   64'(0));
        checkOutput("rst_overrun", 64'(overrun_o[sel]), 64'(0));
        checkOutput("rst_snr",     64'(snr_o[sel]),     64'(snr));
        checkOutput("rst_frames",  64'(frames_o[sel]),  64'(0));
        checkOutput("rst_berr",    64'(berr_o[sel]),    64'(0));
    endtask

    task automatic startSweep(input int sel);
        start_s[sel] = 1'b1;
        @(negedge clk);
        start_s[sel] = 1'b0;
        m_frames[sel] = 0;
        m_ferr[sel]   = 0;
        m_berr[sel]   = 0;
        m_snr[sel]    = snrFirst(sel);
    endtask

    task automatic waitRun(input int sel);
        int guard = 0;
        while (stall_o[sel] !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stall_release", 64'(stall_o[sel]), 64'(0));
    endtask

    // Launches one frame and updates the reference counters; a closing frame queues its record.
    task automatic applyStimulus(input int sel, input logic [DIM-1:0] bits, input logic err,
                                 input logic trace);
        waitRun(sel);
        res_s[sel]  = bits;
        ferr_s[sel] = err;
        term_s[sel] = 1'b1;
        #1;
        if (trace) checkOutput("stall_edge", 64'(stall_o[sel]), 64'(1));
        @(negedge clk);
        term_s[sel] = 1'b0;
        if (trace) begin
            for (int k = 1; k <= 39; k++) begin
                #1;
                checkOutput($sformatf("stall_k%0d", k), 64'(stall_o[sel]), 64'((k <= 38) ? 1 : 0));
                if (k < 39) @(negedge clk);
            end
        end
        m_frames[sel]++;
        if (err) m_ferr[sel]++;
        m_berr[sel] += $countones(bits);
        if (m_ferr[sel] >= feTarget(sel) || m_frames[sel] >= 5) begin
            exp_q.push_back('{snr: 4'(m_snr[sel]), frames: 32'(m_frames[sel]),
                              ferr: 32'(m_ferr[sel]), berr: 32'(m_berr[sel])});
            m_frames[sel] = 0;
            m_ferr[sel]   = 0;
            m_berr[sel]   = 0;
            if (m_snr[sel] != snrLast(sel)) m_snr[sel]++;
        end
    endtask

    task automatic checkRecord(input int sel, input int hold);
        int   guard = 0;
        rec_t e;
        while (valid_o[sel] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rpt_valid_wait", 64'(valid_o[sel]), 64'(1));
        checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int h = 0; h <= hold; h++) begin
            checkOutput("rpt_valid_hold", 64'(valid_o[sel]),  64'(1));
            checkOutput("rpt_snr",        64'(rsnr_o[sel]),   64'(e.snr));
            checkOutput("snr_idx_hold",   64'(snr_o[sel]),    64'(e.snr));
            checkOutput("rpt_frames",     64'(frames_o[sel]), 64'(e.frames));
            checkOutput("rpt_ferr",       64'(ferrc_o[sel]),  64'(e.ferr));
            checkOutput("rpt_berr",       64'(berr_o[sel]),   64'(e.berr));
            if (h < hold) @(negedge clk);
        end
        ready_s[sel] = 1'b1;
        @(negedge clk);
        ready_s[sel] = 1'b0;
        checkOutput("rpt_valid_drop", 64'(valid_o[sel]), 64'(0));
        if (32'(e.snr) == 32'(snrLast(sel))) begin
            checkOutput("done_set", 64'(done_o[sel]), 64'(1));
            checkOutput("busy_clr", 64'(busy_o[sel]), 64'(0));
        end else begin
            checkOutput("snr_step", 64'(snr_o[sel]),  64'(e.snr + 4'd1));
            checkOutput("done_clr", 64'(done_o[sel]), 64'(0));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DIM-1:0] b;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            term_s[s]  = 1'b0;
            ferr_s[s]  = 1'b0;
            ready_s[s] = 1'b0;
            res_s[s]   = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkIdle(0, 10);
        checkIdle(1, 3);

        $display("[TB] single point, five clean frames");
        startSweep(0);
        checkOutput("run_busy", 64'(busy_o[0]), 64'(1));
        checkOutput("run_stall", 64'(stall_o[0]), 64'(0));
        repeat (5) applyStimulus(0, '0, 1'b0, 1'b0);
        checkRecord(0, 0);

        $display("[TB] boundary bits, stall window, held record");
        startSweep(0);
        checkOutput("restart_done", 64'(done_o[0]), 64'(0));
        b = '0;
        b[0] = 1'b1; b[63] = 1'b1; b[64] = 1'b1; b[2303] = 1'b1;
        applyStimulus(0, b, 1'b1, 1'b1);
        checkOutput("f1_frames", 64'(frames_o[0]), 64'(1));
        checkOutput("f1_ferr",   64'(ferrc_o[0]),  64'(1));
        checkOutput("f1_berr",   64'(berr_o[0]),   64'(4));
        b = '0;
        b[127] = 1'b1; b[128] = 1'b1; b[1000] = 1'b1;
        applyStimulus(0, b, 1'b1, 1'b0);
        checkRecord(0, 20);

        $display("[TB] overrun during COUNT");
        startSweep(0);
        checkOutput("ovr_clear0", 64'(overrun_o[0]), 64'(0));
        b = '0;
        b[1] = 1'b1; b[2] = 1'b1; b[3] = 1'b1; b[700] = 1'b1; b[2000] = 1'b1;
        applyStimulus(0, b, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        res_s[0]  = '1;
        ferr_s[0] = 1'b1;
        term_s[0] = 1'b1;
        @(negedge clk);
        term_s[0] = 1'b0;
        #1;
        checkOutput("ovr_set", 64'(overrun_o[0]), 64'(1));
        waitRun(0);
        checkOutput("ovr_frames", 64'(frames_o[0]), 64'(1));
        checkOutput("ovr_ferr",   64'(ferrc_o[0]),  64'(1));
        checkOutput("ovr_berr",   64'(berr_o[0]),   64'(5));
        b = '0;
        b[1500] = 1'b1;
        applyStimulus(0, b, 1'b1, 1'b0);
        checkRecord(0, 0);
        checkOutput("ovr_sticky", 64'(overrun_o[0]), 64'(1));
        startSweep(0);
        checkOutput("ovr_start_clr", 64'(overrun_o[0]), 64'(0));

        $display("[TB] sweep 3..5");
        startSweep(1);
        for (int s = 3; s <= 5; s++) begin
            b = '0;
            for (int j = 0; j < s; j++) b[j * 100 + s] = 1'b1;
            applyStimulus(1, b, 1'b1, 1'b0);
            checkRecord(1, 0);
        end

        $display("[TB] reset during COUNT");
        startSweep(1);
        b = '0;
        b[10] = 1'b1; b[20] = 1'b1;
        res_s[1]  = b;
        ferr_s[1] = 1'b1;
        term_s[1] = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_busy", 64'(busy_o[1]), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle(1, 3);
        checkOutput("rst_busy_a", 64'(busy_o[0]), 64'(0));
        startSweep(1);
        repeat (5) @(negedge clk);
        checkOutput("held_term_stall",  64'(stall_o[1]),  64'(0));
        checkOutput("held_term_busy",   64'(busy_o[1]),   64'(1));
        checkOutput("held_term_frames", 64'(frames_o[1]), 64'(0));
        checkOutput("held_term_valid",  64'(valid_o[1]),  64'(0));
        term_s[1] = 1'b0;
        @(negedge clk);
        applyStimulus(1, b, 1'b1, 1'b0);
        checkRecord(1, 0);
        checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ber_fer_monitor.md
Name: ber_fer_monitor

Overview:
- Downstream consumer of the LDPC decoder core in the noise-only test harness.
- The transmitted codeword is all-zero, so any '1' in the decoded word is a bit error.
- Snapshots each decoded frame at decoder termination, counts frames, frame errors (core err flag) and bit errors (serial popcount), and steps the harness SNR index through a sweep.
- Publishes one result record per SNR point over a valid/ready handshake.

Parameters:
- DIM, 2304, decoded word width (R*D).
- CHUNK, 64, bits popcounted per cycle; DIM must be a multiple of CHUNK.
- CNT_W, 32, width of the frame and bit-error counters.
- FE_TARGET, 100, frame errors that close an SNR point.
- MAX_FRAMES, 100000, frames that close an SNR point regardless of errors.
- SNR_FIRST, 0, first snr_idx value (4 bits).
- SNR_LAST, 10, last snr_idx value (4 bits).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, pulse; begins a sweep from IDLE or DONE.
- term, in, 1, decoder terminated (level).
- frame_err, in, 1, decoder frame-error flag; valid while term is high.
- res, in, DIM, decoded hard decisions; valid while term is high.
- stall, out, 1, high tells the stimulus side not to launch a new frame.
- snr_idx, out, 4, current SNR index driven to the quantizers.
- rpt_valid, out, 1, result record valid.
- rpt_ready, in, 1, result record accepted.
- rpt_snr, out, 4, SNR index of the record.
- rpt_frames, out, CNT_W, frames counted.
- rpt_ferr, out, CNT_W, frame errors.
- rpt_berr, out, CNT_W, bit errors.
- overrun, out, 1, sticky; a termination arrived while the block was busy.
- busy, out, 1, FSM is not in IDLE or DONE.
- done, out, 1, sweep complete.

Behaviour:
- Reset:
  - All counters 0; snr_idx = SNR_FIRST; FSM = IDLE.
  - rpt_valid, overrun, busy, done = 0; stall = 1.
  - term edge register = 1, so a term already high at reset release is not counted.
  - A reset mid-sweep aborts everything. No record is emitted.
- Termination event: rising edge of term, detected with one register.
- IDLE:
  - stall = 1.
  - On start: clear counters, snr_idx = SNR_FIRST, go to RUN.
- RUN:
  - stall = 0.
  - On a term edge: latch res into a shadow register and frame_err into ferr_q, increment frames, increment ferr if frame_err. Go to COUNT and set stall = 1 in the same cycle.
- COUNT:
  - Walks the shadow register LSB chunk first, one CHUNK per cycle, for DIM/CHUNK cycles (36 at default).
  - Chunk popcount is registered, so the last chunk's sum is accumulated one cycle after the last chunk index.
  - Accumulation into berr saturates at 2^CNT_W-1.
  - Frame latency from the term edge to the CHECK state is DIM/CHUNK+2 cycles.
- CHECK:
  - If ferr ≥ FE_TARGET or frames ≥ MAX_FRAMES: go to REPORT.
  - Otherwise go to RUN.
- REPORT:
  - rpt_valid = 1 with the record fields held stable.
  - Hold until rpt_valid && rpt_ready.
  - On that handshake cycle: if snr_idx == SNR_LAST go to DONE, else snr_idx + 1, clear the counters, go to RUN.
  - rpt_valid is deasserted the cycle after the handshake.
- DONE:
  - done = 1, stall = 1.
  - start goes to RUN with SNR_FIRST; done drops.
- Overrun: a term edge in COUNT, CHECK or REPORT sets overrun (sticky until rst or start). That frame is dropped: no counter changes.
- Simultaneous start and term edge in IDLE: start wins; the edge is ignored.
- frames and ferr saturate at 2^CNT_W-1.
- start outside IDLE/DONE is ignored.

Decomposition:
- Package ber_mon_pkg holds:
  - the FSM state encoding (IDLE, RUN, COUNT, CHECK, REPORT, DONE);
  - the SNR index width (4);
  - the chunk index width, clog2(DIM/CHUNK);
  - the saturating-increment function.
- Sub-module popcnt_chunk: parameter CHUNK; one registered output of clog2(CHUNK)+1 bits; latency 1.

Test Plan:
1. rst, then start with SNR_FIRST=SNR_LAST=10, FE_TARGET=2, MAX_FRAMES=5. Five term edges with res=0, frame_err=0 → one record: snr 10, frames 5, ferr 0, berr 0; then done=1.
2. One term edge with res bits 0, 63, 64 and 2303 set, frame_err=1 → berr += 4, ferr += 1. stall is high from the edge cycle until the return to RUN, i.e. the edge cycle through edge+38.
3. Sweep SNR 3..5 with FE_TARGET=1, every frame frame_err=1 → exactly three records with rpt_snr 3, 4, 5. snr_idx increments only on the handshake; done is set after the third.
4. Hold rpt_ready=0 for 20 cycles in REPORT → rpt_valid and all fields stable; snr_idx unchanged; no counting.
5. Term edge during COUNT → overrun=1; frames unchanged by the second edge; berr reflects only the first frame.
6. Assert rst in the middle of COUNT → the next cycle shows all outputs at reset values, busy=0, no record emitted. term held high across the reset release is not counted.
